// File: rtl/ipv4_tx_frame_arbiter.sv
// Frame-atomic round-robin arbiter sharing one IPv4 transmit path among NUM_PORTS L4 requesters.
// A whole frame is forwarded with one register stage, followed by an inter-frame gap and guarded by a stall watchdog.
module ipv4_tx_frame_arbiter #(
  parameter int NUM_PORTS      = 3,
  parameter int DATA_WIDTH     = 32,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS-1:0]            req,
  output logic [NUM_PORTS-1:0]            grant,
  input  logic [NUM_PORTS-1:0]            in_data_valid,
  input  logic [NUM_PORTS*3-1:0]          in_bytes_valid,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_PORTS-1:0]            in_commit,
  input  logic [NUM_PORTS-1:0]            in_drop,
  input  logic                            out_ready,
  output logic                            out_start,
  output logic                            out_data_valid,
  output logic [2:0]                      out_bytes_valid,
  output logic [DATA_WIDTH-1:0]           out_data,
  output logic                            out_commit,
  output logic                            out_drop,
  output logic [15:0]                     perf_timeouts
);

  localparam int PTR_W = (NUM_PORTS > 2) ? $clog2(NUM_PORTS) : 1;
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GAP_W = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, ACTIVE, GAP} state_t;

  state_t                  state_q, state_d;
  logic [PTR_W-1:0]        sel_q, sel_d;
  logic [PTR_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [WD_W-1:0]         wd_q, wd_d;
  logic [GAP_W-1:0]        gap_q, gap_d;
  logic [NUM_PORTS-1:0]    grant_d;
  logic                    start_d, dv_d, commit_d, drop_d, end_frame;
  logic [2:0]              bv_d;
  logic [DATA_WIDTH-1:0]   data_d;
  logic [15:0]             perf_d;

  logic [2*NUM_PORTS-1:0]  req_dbl;
  logic [NUM_PORTS-1:0]    req_rot;
  logic                    pick_found;
  logic [PTR_W-1:0]        pick_idx;
  int                      pick_off;
  int                      pick_sum;

  // Rotate requests so that bit 0 is rr_ptr; the lowest set bit is the round-robin winner.
  always_comb begin
    req_dbl    = {req, req} >> rr_ptr_q;
    req_rot    = req_dbl[NUM_PORTS-1:0];
    pick_found = |req_rot;
    pick_off   = 0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (req_rot[i]) pick_off = i;
    end
    pick_sum = int'(rr_ptr_q) + pick_off;
    if (pick_sum >= NUM_PORTS) pick_sum = pick_sum - NUM_PORTS;
    pick_idx = PTR_W'(pick_sum);
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    rr_ptr_d  = rr_ptr_q;
    wd_d      = wd_q;
    gap_d     = gap_q;
    perf_d    = perf_timeouts;
    grant_d   = '0;
    start_d   = 1'b0;
    dv_d      = 1'b0;
    bv_d      = '0;
    data_d    = '0;
    commit_d  = 1'b0;
    drop_d    = 1'b0;
    end_frame = 1'b0;

    case (state_q)
      IDLE: begin
        if (out_ready && pick_found) begin
          sel_d             = pick_idx;
          grant_d[pick_idx] = 1'b1;
          start_d           = 1'b1;
          wd_d              = '0;
          state_d           = ACTIVE;
        end
      end

      ACTIVE: begin
        grant_d = grant;
        dv_d    = in_data_valid[sel_q];
        bv_d    = in_bytes_valid[int'(sel_q)*3 +: 3];
        data_d  = in_data[int'(sel_q)*DATA_WIDTH +: DATA_WIDTH];
        // A real end of frame beats the watchdog if both land in the same cycle.
        if (in_commit[sel_q] || in_drop[sel_q]) begin
          commit_d  = in_commit[sel_q] & ~in_drop[sel_q];
          drop_d    = in_drop[sel_q];
          end_frame = 1'b1;
        end else if (in_data_valid[sel_q]) begin
          wd_d = '0;
        end else if (int'(wd_q) >= TIMEOUT_CYCLES - 1) begin
          drop_d    = 1'b1;
          end_frame = 1'b1;
          perf_d    = (perf_timeouts == 16'hFFFF) ? perf_timeouts : perf_timeouts + 16'd1;
        end else begin
          wd_d = wd_q + 1'b1;
        end

        if (end_frame) begin
          grant_d  = '0;
          rr_ptr_d = (int'(sel_q) == NUM_PORTS - 1) ? '0 : sel_q + 1'b1;
          gap_d    = '0;
          state_d  = (GAP_CYCLES == 0) ? IDLE : GAP;
        end
      end

      GAP: begin
        if (int'(gap_q) >= GAP_CYCLES - 1) state_d = IDLE;
        else                               gap_d   = gap_q + 1'b1;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      sel_q           <= '0;
      rr_ptr_q        <= '0;
      wd_q            <= '0;
      gap_q           <= '0;
      grant           <= '0;
      out_start       <= 1'b0;
      out_data_valid  <= 1'b0;
      out_bytes_valid <= '0;
      out_data        <= '0;
      out_commit      <= 1'b0;
      out_drop        <= 1'b0;
      perf_timeouts   <= '0;
    end else begin
      state_q         <= state_d;
      sel_q           <= sel_d;
      rr_ptr_q        <= rr_ptr_d;
      wd_q            <= wd_d;
      gap_q           <= gap_d;
      grant           <= grant_d;
      out_start       <= start_d;
      out_data_valid  <= dv_d;
      out_bytes_valid <= bv_d;
      out_data        <= data_d;
      out_commit      <= commit_d;
      out_drop        <= drop_d;
      perf_timeouts   <= perf_d;
    end
  end

endmodule

// File: tb/tb_ipv4_tx_frame_arbiter.sv
// Self-checking bench for ipv4_tx_frame_arbiter: scenario tasks with a scoreboard of expected forwarded beats.
module tb_ipv4_tx_frame_arbiter;

  localparam int NP  = 3;
  localparam int DW  = 32;
  localparam int GAP = 2;
  localparam int TMO = 1024;

  logic              clk = 1'b0;
  logic              rst;
  logic [NP-1:0]     req;
  logic [NP-1:0]     grant;
  logic [NP-1:0]     in_data_valid;
  logic [NP*3-1:0]   in_bytes_valid;
  logic [NP*DW-1:0]  in_data;
  logic [NP-1:0]     in_commit;
  logic [NP-1:0]     in_drop;
  logic              out_ready;
  logic              out_start;
  logic              out_data_valid;
  logic [2:0]        out_bytes_valid;
  logic [DW-1:0]     out_data;
  logic              out_commit;
  logic              out_drop;
  logic [15:0]       perf_timeouts;

  typedef struct packed {
    logic          dv;
    logic [2:0]    bv;
    logic [DW-1:0] data;
    logic          commit;
    logic          drop;
  } beat_t;

  beat_t exp_q[$];
  int    checks   = 0;
  int    failures = 0;

  always #5 clk = ~clk;

  ipv4_tx_frame_arbiter #(
    .NUM_PORTS(NP), .DATA_WIDTH(DW), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .grant(grant),
    .in_data_valid(in_data_valid), .in_bytes_valid(in_bytes_valid), .in_data(in_data),
    .in_commit(in_commit), .in_drop(in_drop), .out_ready(out_ready),
    .out_start(out_start), .out_data_valid(out_data_valid), .out_bytes_valid(out_bytes_valid),
    .out_data(out_data), .out_commit(out_commit), .out_drop(out_drop),
    .perf_timeouts(perf_timeouts)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_data_valid  = '0;
    in_bytes_valid = '0;
    in_data        = '0;
    in_commit      = '0;
    in_drop        = '0;
  endtask

  // Non-target ports carry distinctive junk so any leakage from an ungranted port shows up on the output.
  task automatic drive_port(input int p, input logic dv, input logic [2:0] bv,
                            input logic [DW-1:0] d, input logic c, input logic dr);
    for (int i = 0; i < NP; i++) begin
      if (i == p) begin
        in_data_valid[i]          = dv;
        in_bytes_valid[i*3 +: 3]  = bv;
        in_data[i*DW +: DW]       = d;
        in_commit[i]              = c;
        in_drop[i]                = dr;
      end else begin
        in_data_valid[i]          = 1'b1;
        in_bytes_valid[i*3 +: 3]  = 3'd2;
        in_data[i*DW +: DW]       = {24'hDEADBE, 8'(i)};
        in_commit[i]              = 1'b0;
        in_drop[i]                = 1'b0;
      end
    end
  endtask

  task automatic send(input int p, input logic dv, input logic [2:0] bv,
                      input logic [DW-1:0] d, input logic c, input logic dr);
    beat_t e;
    drive_port(p, dv, bv, d, c, dr);
    e = '{dv, bv, d, c & ~dr, dr};
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req       = '0;
    out_ready = 1'b1;
    idle_inputs();
    tick();
    tick();
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    req       = '1;
    out_ready = 1'b1;
    drive_port(0, 1'b1, 3'd4, 32'h11223344, 1'b1, 1'b1);
    tick();
    tick();
    checks++;
    if (grant !== '0) begin
      failures++; $display("[TB] FAIL reset_grant: actual %b required 000", grant);
    end
    checks++;
    if ({out_start, out_data_valid, out_commit, out_drop} !== 4'b0) begin
      failures++;
      $display("[TB] FAIL reset_pulses: actual start/dv/commit/drop %b required 0000",
               {out_start, out_data_valid, out_commit, out_drop});
    end
    checks++;
    if ({out_bytes_valid, out_data} !== '0) begin
      failures++; $display("[TB] FAIL reset_data: actual %h/%h required 0/0", out_bytes_valid, out_data);
    end
    checks++;
    if (perf_timeouts !== 16'd0) begin
      failures++; $display("[TB] FAIL reset_perf: actual %0d required 0", perf_timeouts);
    end
    rst = 1'b0;
    req = '0;
    idle_inputs();
  endtask

  task automatic test_single_port();
    logic [DW-1:0] beat_data [3];
    logic [2:0]    beat_bv   [3];
    beat_t         act, e;
    int            n;
    beat_data = '{32'hA1A2A3A4, 32'hB1B2B3B4, 32'hC1C2C300};
    beat_bv   = '{3'd4, 3'd4, 3'd3};
    do_reset();
    req = 3'b010;
    n = 0;
    do begin tick(); n++; end while (out_start !== 1'b1 && n < 10);
    checks++;
    if (out_start !== 1'b1 || grant !== 3'b010 || out_data_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL single_start: actual start=%b grant=%b dv=%b required 1/010/0", out_start, grant, out_data_valid);
    end
    for (int b = 0; b < 3; b++) begin
      send(1, 1'b1, beat_bv[b], beat_data[b], b == 2, 1'b0);
      tick();
      act = {out_data_valid, out_bytes_valid, out_data, out_commit, out_drop};
      checks++;
      if (exp_q.size() == 0) begin
        failures++; $display("[TB] FAIL single_beat%0d: actual %h with empty scoreboard", b, act);
      end else begin
        e = exp_q.pop_front();
        if (act !== e) begin
          failures++; $display("[TB] FAIL single_beat%0d: actual %h required %h", b, act, e);
        end
      end
      checks++;
      if (grant !== ((b == 2) ? 3'b000 : 3'b010)) begin
        failures++; $display("[TB] FAIL single_grant%0d: actual %b", b, grant);
      end
    end
    idle_inputs();
    for (int g = 0; g < GAP; g++) begin
      tick();
      checks++;
      if ({grant, out_start, out_data_valid, out_commit, out_drop} !== '0) begin
        failures++;
        $display("[TB] FAIL single_gap%0d: actual grant=%b start=%b dv=%b required all 0", g, grant, out_start, out_data_valid);
      end
    end
    tick();
    checks++;
    if (out_start !== 1'b1 || grant !== 3'b010) begin
      failures++; $display("[TB] FAIL single_regrant: actual start=%b grant=%b required 1/010", out_start, grant);
    end
    send(1, 1'b0, 3'd0, 32'd0, 1'b0, 1'b1);
    tick();
    act = {out_data_valid, out_bytes_valid, out_data, out_commit, out_drop};
    checks++;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
    if (act !== e) begin
      failures++; $display("[TB] FAIL single_drop_end: actual %h required %h", act, e);
    end
    req = '0;
    idle_inputs();
  endtask

  task automatic test_round_robin();
    beat_t         act, e;
    logic [NP-1:0] exp_grant;
    int            n, starts;
    do_reset();
    req    = 3'b111;
    starts = 0;
    for (int f = 0; f < 6; f++) begin
      exp_grant = 3'b001 << (f % NP);
      n = 0;
      do begin
        tick(); n++;
        if (out_start === 1'b1) starts++;
      end while (out_start !== 1'b1 && n < 10);
      checks++;
      if (grant !== exp_grant) begin
        failures++; $display("[TB] FAIL rr_grant%0d: actual %b required %b", f, grant, exp_grant);
      end
      send(f % NP, 1'b1, 3'd4, 32'h10000000 + f, 1'b1, 1'b0);
      tick();
      act = {out_data_valid, out_bytes_valid, out_data, out_commit, out_drop};
      checks++;
      e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
      if (act !== e || out_start !== 1'b0 || grant !== '0) begin
        failures++;
        $display("[TB] FAIL rr_beat%0d: actual %h start=%b grant=%b required %h 0 000", f, act, out_start, grant, e);
      end
      idle_inputs();
    end
    checks++;
    if (starts !== 6) begin
      failures++; $display("[TB] FAIL rr_start_count: actual %0d required 6", starts);
    end
    req = '0;
  endtask

  task automatic test_commit_drop();
    beat_t act, e;
    int    n;
    do_reset();
    req = 3'b001;
    n = 0;
    do begin tick(); n++; end while (out_start !== 1'b1 && n < 10);
    checks++;
    if (grant !== 3'b001) begin
      failures++; $display("[TB] FAIL cd_grant: actual %b required 001", grant);
    end
    send(0, 1'b1, 3'd4, 32'h5A5A5A5A, 1'b1, 1'b1);
    tick();
    act = {out_data_valid, out_bytes_valid, out_data, out_commit, out_drop};
    checks++;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
    if (act !== e) begin
      failures++; $display("[TB] FAIL cd_beat: actual %h required %h", act, e);
    end
    checks++;
    if (grant !== '0) begin
      failures++; $display("[TB] FAIL cd_release: actual %b required 000", grant);
    end
    req = '0;
    idle_inputs();
  endtask

  task automatic test_timeout();
    beat_t e;
    int    n;
    do_reset();
    req = 3'b100;
    n = 0;
    do begin tick(); n++; end while (out_start !== 1'b1 && n < 10);
    checks++;
    if (grant !== 3'b100) begin
      failures++; $display("[TB] FAIL to_grant: actual %b required 100", grant);
    end
    req = 3'b101;
    drive_port(2, 1'b0, 3'd0, 32'd0, 1'b0, 1'b0);
    e = '{1'b0, 3'd0, 32'd0, 1'b0, 1'b1};
    exp_q.push_back(e);
    n = 0;
    do begin tick(); n++; end while (out_drop !== 1'b1 && n < TMO + 50);
    checks++;
    if (n !== TMO) begin
      failures++; $display("[TB] FAIL to_cycle: actual drop after %0d cycles required %0d", n, TMO);
    end
    checks++;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
    if ({out_data_valid, out_commit, out_drop} !== {e.dv, e.commit, e.drop}) begin
      failures++;
      $display("[TB] FAIL to_pulse: actual dv/commit/drop %b required %b",
               {out_data_valid, out_commit, out_drop}, {e.dv, e.commit, e.drop});
    end
    checks++;
    if (perf_timeouts !== 16'd1 || grant !== '0) begin
      failures++; $display("[TB] FAIL to_perf: actual perf=%0d grant=%b required 1/000", perf_timeouts, grant);
    end
    idle_inputs();
    n = 0;
    do begin tick(); n++; end while (out_start !== 1'b1 && n < 10);
    checks++;
    if (out_start !== 1'b1 || grant !== 3'b001) begin
      failures++; $display("[TB] FAIL to_next_grant: actual start=%b grant=%b required 1/001", out_start, grant);
    end
    req = '0;
  endtask

  task automatic test_out_ready();
    beat_t act, e;
    do_reset();
    out_ready = 1'b0;
    req       = 3'b111;
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if (out_start !== 1'b0 || grant !== '0) begin
        failures++; $display("[TB] FAIL ready_hold%0d: actual start=%b grant=%b required 0/000", k, out_start, grant);
      end
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_start !== 1'b1 || grant !== 3'b001) begin
      failures++; $display("[TB] FAIL ready_grant: actual start=%b grant=%b required 1/001", out_start, grant);
    end
    out_ready = 1'b0;
    for (int b = 0; b < 2; b++) begin
      send(0, 1'b1, (b == 1) ? 3'd2 : 3'd4, 32'h01020304 + b, b == 1, 1'b0);
      tick();
      act = {out_data_valid, out_bytes_valid, out_data, out_commit, out_drop};
      checks++;
      e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
      if (act !== e) begin
        failures++; $display("[TB] FAIL ready_beat%0d: actual %h required %h", b, act, e);
      end
    end
    checks++;
    if (grant !== '0) begin
      failures++; $display("[TB] FAIL ready_release: actual %b required 000", grant);
    end
    out_ready = 1'b1;
    req = '0;
    idle_inputs();
  endtask

  task automatic test_reset_mid_frame();
    beat_t act, e;
    int    n;
    do_reset();
    req = 3'b010;
    n = 0;
    do begin tick(); n++; end while (out_start !== 1'b1 && n < 10);
    send(1, 1'b1, 3'd4, 32'hCAFE0001, 1'b1, 1'b0);
    tick();
    act = {out_data_valid, out_bytes_valid, out_data, out_commit, out_drop};
    checks++;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
    if (act !== e) begin
      failures++; $display("[TB] FAIL rmf_first_frame: actual %h required %h", act, e);
    end
    idle_inputs();
    req = 3'b100;
    n = 0;
    do begin tick(); n++; end while (out_start !== 1'b1 && n < 10);
    checks++;
    if (grant !== 3'b100) begin
      failures++; $display("[TB] FAIL rmf_grant2: actual %b required 100", grant);
    end
    send(2, 1'b1, 3'd4, 32'hCAFE0002, 1'b0, 1'b0);
    tick();
    act = {out_data_valid, out_bytes_valid, out_data, out_commit, out_drop};
    checks++;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
    if (act !== e) begin
      failures++; $display("[TB] FAIL rmf_beat: actual %h required %h", act, e);
    end
    drive_port(2, 1'b1, 3'd4, 32'hCAFE0003, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    exp_q.delete();
    checks++;
    if ({grant, out_start, out_data_valid, out_commit} !== '0) begin
      failures++;
      $display("[TB] FAIL rmf_outputs: actual grant=%b start=%b dv=%b commit=%b required all 0",
               grant, out_start, out_data_valid, out_commit);
    end
    checks++;
    if (out_drop !== 1'b0) begin
      failures++; $display("[TB] FAIL rmf_no_drop: actual %b required 0", out_drop);
    end
    rst = 1'b0;
    idle_inputs();
    req = 3'b111;
    n = 0;
    do begin tick(); n++; end while (out_start !== 1'b1 && n < 10);
    checks++;
    if (out_start !== 1'b1 || grant !== 3'b001) begin
      failures++; $display("[TB] FAIL rmf_first_grant: actual start=%b grant=%b required 1/001", out_start, grant);
    end
    req = '0;
  endtask

  initial begin
    rst       = 1'b1;
    req       = '0;
    out_ready = 1'b0;
    idle_inputs();
    test_reset();
    test_single_port();
    test_round_robin();
    test_commit_drop();
    test_timeout();
    test_out_ready();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/ipv4_tx_frame_arbiter.md
Name: ipv4_tx_frame_arbiter

Overview:
- Frame-atomic, round-robin arbiter that shares one IPv4 L3 transmit path among NUM_PORTS layer-4 requesters (ICMP, TCP, UDP, future protocols).
- Grants one requester at a time for a whole frame and forwards its beats downstream with one register stage.
- Enforces an inter-frame gap and a stall watchdog so that a hung requester cannot lock the shared path.

Parameters:
NUM_PORTS, 3, number of requesters (2..8)
DATA_WIDTH, 32, payload beat width in bits
GAP_CYCLES, 2, idle cycles inserted after each frame before the next grant (0 allowed)
TIMEOUT_CYCLES, 1024, cycles of granted-port inactivity before a forced abort

Ports:
clk  in  1  stack clock; all logic on the rising edge
rst  in  1  synchronous, active-high reset
req  in  NUM_PORTS  per-port frame request (level)
grant  out  NUM_PORTS  one-hot grant, registered
in_data_valid  in  NUM_PORTS  per-port beat valid
in_bytes_valid  in  NUM_PORTS*3  per-port count of valid bytes in the beat (1..4)
in_data  in  NUM_PORTS*DATA_WIDTH  per-port beat data
in_commit  in  NUM_PORTS  per-port end of frame, frame good
in_drop  in  NUM_PORTS  per-port end of frame, frame discarded
out_ready  in  1  downstream can accept a new frame
out_start  out  1  one-cycle pulse marking the start of a frame
out_data_valid  out  1  forwarded beat valid
out_bytes_valid  out  3  forwarded byte count
out_data  out  DATA_WIDTH  forwarded data
out_commit  out  1  forwarded commit pulse
out_drop  out  1  forwarded or forced drop pulse
perf_timeouts  out  16  saturating count of watchdog aborts

Behaviour:
- Reset:
  - All outputs 0; perf_timeouts 0; rr_ptr 0; state IDLE.
  - Reset mid-frame produces no out_drop. Downstream is reset together with this block.
- States: IDLE, ACTIVE, GAP.
- IDLE:
  - If out_ready=1 and req is nonzero, select the first asserted req index at or after rr_ptr (wrapping modulo NUM_PORTS).
  - Next cycle: grant[sel]=1 and out_start=1 for exactly that one cycle. Enter ACTIVE.
  - If out_ready=0, no grant is issued and requests are held.
- ACTIVE:
  - Only the granted port's in_* signals are sampled. Every other port's in_* signals are ignored.
  - Each sampled in_* appears on the matching out_* one cycle later; forwarding latency is 1 cycle.
  - out_ready is not consulted mid-frame.
  - Deassertion of req by the granted port mid-frame is ignored. The grant holds until commit, drop or timeout.
  - Granted in_commit or in_drop sampled:
    - Forward it, including any data beat in the same cycle.
    - grant goes to 0 on the same edge that registers the forwarded pulse.
    - rr_ptr = (sel+1) mod NUM_PORTS.
    - Enter GAP, or IDLE if GAP_CYCLES=0.
  - in_commit and in_drop in the same cycle: drop wins (out_drop=1, out_commit=0).
  - Watchdog counter:
    - Cleared on grant and on any granted-port in_data_valid.
    - Increments otherwise.
    - On reaching TIMEOUT_CYCLES: out_drop=1 for one cycle, grant cleared, perf_timeouts += 1 (saturates at 0xFFFF), rr_ptr advanced as above, enter GAP/IDLE.
- GAP:
  - Count GAP_CYCLES cycles with all out_* at 0 and grant=0, then IDLE.
  - Requests arriving during GAP are served in the IDLE arbitration that follows.
- out_start never coincides with out_data_valid.
- The first forwarded beat appears no earlier than the cycle after out_start.
- Minimum turnaround is end pulse → GAP_CYCLES → 1 IDLE cycle → next out_start.
- in_bytes_valid is passed through unmodified. A value of 0 with data_valid=1 is forwarded as-is (the requester's error).
- Simultaneous requests are resolved purely by rr_ptr. No port wins twice in a row while another port is requesting.

Test Plan:
- Single port 1: req[1]=1; 3 beats 0xA1A2A3A4, 0xB1B2B3B4, 0xC1C2C3xx (bytes_valid 4,4,3); commit with the last beat. Required response: out_start pulse, grant=3'b010, beats out 1 cycle after input, out_commit aligned with beat 3, grant=0 afterwards, 2 idle cycles before any new grant.
- All three req high continuously, 1-beat frames, after reset. Required response: grant order 0,1,2,0,1,2; exactly one out_start per frame.
- Granted port asserts commit and drop in the same cycle. Required response: out_drop=1, out_commit=0, grant released.
- Granted port 2 stalls with no data_valid for 1024 cycles. Required response: out_drop pulse at cycle 1024, perf_timeouts=1, next grant goes to port 0 if it is requesting.
- out_ready=0 while req=3'b111. Required response: no out_start and no grant. Raise out_ready to 1: grant is issued next cycle. Drop out_ready mid-frame: the frame still completes normally.
- Assert rst mid-frame. Required response: all outputs 0 next cycle, no out_drop, and the first grant after reset goes to port 0.
